// File: rtl/scr1_dmem_arb_pkg.sv
// scr1_dmem_arb_pkg: memif types and constants shared by the DMEM arbiter slice
package scr1_dmem_arb_pkg;

    localparam int SCR1_DMEM_AWIDTH    = 32;
    localparam int SCR1_DMEM_DWIDTH    = 32;
    localparam int SCR1_DMEM_ARB_TMO_W = 10;

    typedef enum logic {
        SCR1_MEM_CMD_RD,
        SCR1_MEM_CMD_WR
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE,
        SCR1_MEM_WIDTH_HWORD,
        SCR1_MEM_WIDTH_WORD
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE,
        SCR1_MEM_RESP_RDY_OK,
        SCR1_MEM_RESP_RDY_ER
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_DMEM_ARB_IDLE,
        SCR1_DMEM_ARB_BUSY,
        SCR1_DMEM_ARB_DRAIN
    } type_scr1_dmem_arb_fsm_e;

endpackage

// File: rtl/scr1_dmem_arb_if.sv
// scr1_dmem_arb_if: SCR1 memif request/acknowledge/response bundle
interface scr1_dmem_arb_if;
    import scr1_dmem_arb_pkg::*;

    logic                        req;
    type_scr1_mem_cmd_e          cmd;
    type_scr1_mem_width_e        width;
    logic [SCR1_DMEM_AWIDTH-1:0] addr;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata;
    logic                        req_ack;
    logic [SCR1_DMEM_DWIDTH-1:0] rdata;
    type_scr1_mem_resp_e         resp;

    modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
    modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);

endinterface

// File: rtl/scr1_arb_rr2.sv
// scr1_arb_rr2: two-input picker, round-robin on ~last or fixed priority to input 0
module scr1_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic       sel
);
    assign sel = (req == 2'b11) ? (mode & ~last) : req[1];
endmodule

// File: rtl/scr1_dmem_arb.sv
// scr1_dmem_arb: shares one DMEM port between two memif masters, one transfer in flight,
// with an optional watchdog that turns a hung response into RDY_ER
module scr1_dmem_arb #(
    parameter bit ARB_RR  = 1'b1,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    scr1_dmem_arb_if.slave  m0,
    scr1_dmem_arb_if.slave  m1,
    scr1_dmem_arb_if.master dmem,
    output logic            arb_busy,
    output logic            arb_tmo
);
    import scr1_dmem_arb_pkg::*;

    localparam logic [SCR1_DMEM_ARB_TMO_W-1:0] TMO_LAST = SCR1_DMEM_ARB_TMO_W'(TIMEOUT - 1);

    type_scr1_dmem_arb_fsm_e          state;
    type_scr1_mem_resp_e              own_resp;
    logic                             owner, last, sel, idle, busy, resp_vld, tmo_fire;
    logic [SCR1_DMEM_ARB_TMO_W-1:0]   tmo_cnt;

    scr1_arb_rr2 u_pick (.req({m1.req, m0.req}), .last(last), .mode(ARB_RR), .sel(sel));

    // a real response in the watchdog cycle takes precedence over the timeout
    always_comb begin
        idle       = rst_n && state == SCR1_DMEM_ARB_IDLE;
        busy       = rst_n && state == SCR1_DMEM_ARB_BUSY;
        resp_vld   = dmem.resp != SCR1_MEM_RESP_IDLE;
        tmo_fire   = busy && TIMEOUT != 0 && !resp_vld && tmo_cnt == TMO_LAST;
        own_resp   = !busy ? SCR1_MEM_RESP_IDLE : tmo_fire ? SCR1_MEM_RESP_RDY_ER : dmem.resp;
        dmem.req   = idle && (sel ? m1.req : m0.req);
        dmem.cmd   = sel ? m1.cmd : m0.cmd;
        dmem.width = sel ? m1.width : m0.width;
        dmem.addr  = sel ? m1.addr : m0.addr;
        dmem.wdata = sel ? m1.wdata : m0.wdata;
        m0.req_ack = idle && !sel && dmem.req_ack;
        m1.req_ack = idle && sel && dmem.req_ack;
        m0.resp    = owner ? SCR1_MEM_RESP_IDLE : own_resp;
        m1.resp    = owner ? own_resp : SCR1_MEM_RESP_IDLE;
        m0.rdata   = dmem.rdata;
        m1.rdata   = dmem.rdata;
        arb_busy   = rst_n && state != SCR1_DMEM_ARB_IDLE;
        arb_tmo    = tmo_fire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SCR1_DMEM_ARB_IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            case (state)
                SCR1_DMEM_ARB_IDLE: if (dmem.req && dmem.req_ack) begin
                    state   <= SCR1_DMEM_ARB_BUSY;
                    owner   <= sel;
                    last    <= sel;
                    tmo_cnt <= '0;
                end
                SCR1_DMEM_ARB_BUSY: begin
                    if (resp_vld) state <= SCR1_DMEM_ARB_IDLE;
                    else if (tmo_fire) state <= SCR1_DMEM_ARB_DRAIN;
                    if (!resp_vld && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
                end
                SCR1_DMEM_ARB_DRAIN: if (resp_vld) state <= SCR1_DMEM_ARB_IDLE;
                default: state <= SCR1_DMEM_ARB_IDLE;
            endcase
        end
    end

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({m0.req, m1.req, state}));
    a_one_resp: assert property (@(posedge clk)
        !(m0.resp != SCR1_MEM_RESP_IDLE && m1.resp != SCR1_MEM_RESP_IDLE));
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n) state == SCR1_DMEM_ARB_IDLE
        |-> (m0.resp == SCR1_MEM_RESP_IDLE && m1.resp == SCR1_MEM_RESP_IDLE));

endmodule
